// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program memory loader.
//  state_t          : loader mode (IDLE, LOAD, RUN)
//  NOP_WORD_DEFAULT : instruction returned for blocked or out-of-range fetches
package prog_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

endpackage

// File: rtl/sp_ram.sv
// DATA_W x DEPTH synchronous RAM: one write port, one registered read port.
//  clk, rst_n : clock, async active-low reset (read register only)
//  we/waddr/wdata : write port
//  re         : read enable; read register holds when low
//  rd_null    : load RD_RST into the read register instead of memory data
//  raddr      : read address
//  rdata      : registered read data
module sp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 255,
  parameter logic [DATA_W-1:0] RD_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rd_null,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array; never reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; rd_null keeps out-of-range addresses off the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= RD_RST;
    end else if (re) begin
      rdata <= rd_null ? RD_RST : mem[raddr];
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Instruction memory with a streaming valid/ready loader and a 1-cycle fetch port.
//  clk, rst_n            : clock, async active-low reset
//  load_start            : pulse, (re)start loading at address 0
//  ld_valid/ld_data/ld_last/ld_ready : load word stream
//  fetch_en/fetch_addr   : fetch request
//  instr_out/instr_valid : registered fetch result
//  load_busy, load_done, load_count, load_err : loader status
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 255,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              accept_c;
  logic              fetch_hit_c;

  // A restart in the same cycle drops the presented word.
  assign accept_c    = ld_valid && ld_ready && !load_start;
  assign fetch_hit_c = (state == RUN) && ({1'b0, fetch_addr} < DEPTH_CNT);

  // Loader FSM with its registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      load_count <= '0;
      load_err   <= 1'b0;
      ld_ready   <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        state      <= LOAD;
        ptr        <= '0;
        load_count <= '0;
        load_err   <= 1'b0;
        ld_ready   <= 1'b1;
        load_busy  <= 1'b1;
      end else begin
        case (state)
          LOAD: begin
            if (accept_c) begin
              ptr        <= ptr + ADDR_W'(1);
              load_count <= load_count + CNT_W'(1);
              if (ld_last || (ptr == LAST_PTR)) begin
                state     <= RUN;
                ld_ready  <= 1'b0;
                load_busy <= 1'b0;
                load_done <= 1'b1;
                if (!ld_last) load_err <= 1'b1;
              end
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

  // Fetch qualifier; holds with fetch_en low like the read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
    end else if (fetch_en) begin
      instr_valid <= fetch_hit_c;
    end
  end

  sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_RST (NOP_WORD)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept_c),
    .waddr   (ptr),
    .wdata   (ld_data),
    .re      (fetch_en),
    .rd_null (!fetch_hit_c),
    .raddr   (fetch_addr),
    .rdata   (instr_out)
  );

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized bench for prog_mem_loader against a per-cycle behavioural model.
module tb_prog_mem_loader;

  localparam int DEPTH = 255;
  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        fetch_en = 1'b0;
  logic [7:0]  fetch_addr = '0;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        load_busy;
  logic        load_done;
  logic [8:0]  load_count;
  logic        load_err;

  always #5 clk = ~clk;

  prog_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .instr_out(instr_out),
    .instr_valid(instr_valid), .load_busy(load_busy), .load_done(load_done),
    .load_count(load_count), .load_err(load_err)
  );

  // Reference model: mode 0=idle 1=loading 2=running; count doubles as write address.
  int          m_mode;
  int          m_count;
  bit          m_err;
  bit          m_done;
  logic [15:0] m_instr;
  bit          m_ivalid;
  bit          m_instr_known;
  logic [15:0] m_mem [256];
  bit          m_known [256];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("ld_ready", 32'(ld_ready), 32'(m_mode == 1));
    check_eq("load_busy", 32'(load_busy), 32'(m_mode == 1));
    check_eq("load_done", 32'(load_done), 32'(m_done));
    check_eq("load_count", 32'(load_count), 32'(m_count));
    check_eq("load_err", 32'(load_err), 32'(m_err));
    check_eq("instr_valid", 32'(instr_valid), 32'(m_ivalid));
    if (m_instr_known) check_eq("instr_out", 32'(instr_out), 32'(m_instr));
  endtask

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_err = 0; m_done = 0;
    m_instr = NOP; m_ivalid = 0; m_instr_known = 1;
  endtask

  // Advance one clock: model the edge from the current inputs, then compare.
  task automatic tick();
    int a;
    a = int'(fetch_addr);
    if (fetch_en) begin
      if (m_mode == 2 && a < DEPTH) begin
        m_instr = m_mem[a]; m_ivalid = 1; m_instr_known = m_known[a];
      end else begin
        m_instr = NOP; m_ivalid = 0; m_instr_known = 1;
      end
    end
    m_done = 0;
    if (load_start) begin
      m_mode = 1; m_count = 0; m_err = 0;
    end else if (m_mode == 1 && ld_valid) begin
      m_mem[m_count] = ld_data;
      m_known[m_count] = 1;
      m_count++;
      if (ld_last || m_count == DEPTH) begin
        m_mode = 2; m_done = 1;
        if (!ld_last) m_err = 1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit ls, input bit v, input logic [15:0] d, input bit last,
                       input bit fe, input logic [7:0] fa);
    load_start = ls; ld_valid = v; ld_data = d; ld_last = last;
    fetch_en = fe; fetch_addr = fa;
  endtask

  task automatic idle_inputs();
    drive(0, 0, 16'h0, 0, 0, 8'h0);
  endtask

  task automatic fetch(input logic [7:0] a);
    drive(0, 0, 16'h0, 0, 1, a);
    tick();
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin m_known[i] = 0; m_mem[i] = '0; end
    model_reset();
    #12 rst_n = 1'b1;
    #1 check_outputs();
    check_eq("rst_instr_out", 32'(instr_out), 32'(NOP));

    // 1: fetch in IDLE is blocked.
    fetch(8'd0);
    check_eq("idle_fetch_valid", 32'(instr_valid), 32'd0);

    // 2: three-word program, then fetch address 1.
    drive(1, 0, 16'h0, 0, 0, 8'h0); tick();
    drive(0, 1, 16'h1111, 0, 0, 8'h0); tick();
    drive(0, 1, 16'h2222, 0, 0, 8'h0); tick();
    drive(0, 1, 16'h3333, 1, 0, 8'h0); tick();
    check_eq("t2_done", 32'(load_done), 32'd1);
    check_eq("t2_count", 32'(load_count), 32'd3);
    idle_inputs(); tick();
    fetch(8'd1);
    check_eq("t2_fetch1", 32'(instr_out), 32'h2222);
    check_eq("t2_fetch1_valid", 32'(instr_valid), 32'd1);
    fetch(8'd255);
    check_eq("t2_oob_valid", 32'(instr_valid), 32'd0);

    // 3: ld_valid toggling; only handshaked words land.
    drive(1, 0, 16'h0, 0, 0, 8'h0); tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, (i % 2) == 0, 16'(16'hA000 + i), i == 6, 0, 8'h0);
      tick();
    end
    check_eq("t3_count", 32'(load_count), 32'd4);
    for (int i = 0; i < 5; i++) fetch(8'(i));

    // 4: overflow with no ld_last.
    drive(1, 0, 16'h0, 0, 0, 8'h0); tick();
    for (int i = 0; i < 600 && m_mode == 1; i++) begin
      drive(0, $urandom_range(0, 3) != 0, 16'($urandom), 0, 0, 8'h0);
      tick();
    end
    check_eq("t4_err", 32'(load_err), 32'd1);
    check_eq("t4_count", 32'(load_count), 32'd255);
    drive(0, 1, 16'hDEAD, 0, 0, 8'h0); tick();
    check_eq("t4_ready_low", 32'(ld_ready), 32'd0);
    idle_inputs();
    fetch(8'd254);
    check_eq("t4_fetch254", 32'(instr_out), 32'(m_mem[254]));

    // 5: restart while a word is presented.
    drive(1, 0, 16'h0, 0, 0, 8'h0); tick();
    drive(0, 1, 16'h5A01, 0, 0, 8'h0); tick();
    drive(0, 1, 16'h5A02, 0, 0, 8'h0); tick();
    drive(1, 1, 16'h5AFF, 0, 0, 8'h0); tick();
    check_eq("t5_restart_count", 32'(load_count), 32'd0);
    check_eq("t5_err_cleared", 32'(load_err), 32'd0);
    drive(0, 1, 16'h7701, 0, 0, 8'h0); tick();
    drive(0, 1, 16'h7702, 1, 0, 8'h0); tick();
    idle_inputs();
    fetch(8'd0);
    check_eq("t5_fetch0", 32'(instr_out), 32'h7701);

    // 6: async reset mid-load.
    drive(1, 0, 16'h0, 0, 0, 8'h0); tick();
    drive(0, 1, 16'h6601, 0, 0, 8'h0); tick();
    drive(0, 1, 16'h6602, 0, 0, 8'h0); tick();
    idle_inputs();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_eq("t6_busy", 32'(load_busy), 32'd0);
    check_eq("t6_count", 32'(load_count), 32'd0);
    check_outputs();
    #3 rst_n = 1'b1;
    tick();
    check_eq("t6_no_done", 32'(load_done), 32'd0);
    fetch(8'd0);
    check_eq("t6_fetch_nop", 32'(instr_out), 32'(NOP));
    drive(1, 0, 16'h0, 0, 0, 8'h0); tick();
    drive(0, 1, 16'h6611, 0, 1, 8'h0); tick();
    check_eq("t6_load_fetch_blocked", 32'(instr_valid), 32'd0);
    drive(0, 1, 16'h6612, 1, 1, 8'h1); tick();
    idle_inputs();
    fetch(8'd1);
    check_eq("t6_reload_fetch1", 32'(instr_out), 32'h6612);

    // Random traffic mixing loads, restarts and fetches.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, 16'($urandom),
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 8'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
